matrix_dot_engine: RTL

Downstream consumer of the matrix loader. Once both 32x32 operand matrices are loaded, it walks every (row, col) pair, fetches A row `i` and B column `j` over the loader's address/data port, and computes their 32-element dot product in a fixed-latency pipeline. It emits one result element per cycle, tagged with its coordinates, to the result transmit stage.

---
 rtl/matrix_dot_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_dot_engine.sv
// matrix_dot_engine: sweeps all (row, col) pairs of two loaded 32x32 byte
// matrices and streams out the 32-element unsigned dot product for each
// pair, one per cycle. Each result carries its row and column tags.
module matrix_dot_engine #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic         inter_refclk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a_row_in,
  input  logic [255:0] b_col_in,
  output logic [4:0]   requested_a_row,
  output logic [4:0]   requested_b_col,
  output logic         result_valid,
  output logic [20:0]  result_data,
  output logic [4:0]   result_row,
  output logic [4:0]   result_col,
  output logic         busy,
  output logic         done
);

  localparam int unsigned N         = 32;
  localparam int unsigned EW        = 8;
  localparam int unsigned PW        = 16;
  localparam int unsigned PSW       = 19;
  localparam int unsigned RW        = 21;
  localparam int unsigned IW        = 5;
  localparam int unsigned NPART     = 4;
  localparam int unsigned PER_PART  = N / NPART;
  // Tag stages before the output register; the output register makes the
  // total issue-to-result latency READ_LATENCY + 3.
  localparam int unsigned TAG_DEPTH = READ_LATENCY + 2;
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
  } tag_t;

  state_e        state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          issue_c;
  logic          pending_c;

  tag_t          tag_q [TAG_DEPTH];
  logic [PW-1:0] prod_q [N];
  logic [PSW-1:0] psum_c [NPART];
  logic [PSW-1:0] psum_q [NPART];
  logic [RW-1:0] sum_c;

  logic          res_valid_q;
  logic [RW-1:0] res_data_q;
  logic [IW-1:0] res_row_q;
  logic [IW-1:0] res_col_q;

  // Any result still travelling through the tag pipeline.
  always_comb begin
    pending_c = 1'b0;
    for (int i = 0; i < int'(TAG_DEPTH); i++) begin
      pending_c = pending_c | tag_q[i].vld;
    end
  end

  // Next-state, address sweep and status decode.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    issue_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        issue_c = 1'b1;
        if (col_q == IDX_MAX) begin
          if (row_q == IDX_MAX) begin
            // Final address issued: hold (31,31) on the request port.
            state_d = S_DRAIN;
          end else begin
            col_d = '0;
            row_d = row_q + IW'(1);
          end
        end else begin
          col_d = col_q + IW'(1);
        end
      end
      S_DRAIN: begin
        if (!pending_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for start to drop so a level-held start cannot re-trigger.
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State, request address and status registers.
  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Tag shift register carrying valid/row/col alongside the data path.
  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TAG_DEPTH); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {issue_c, row_q, col_q};
      for (int i = 1; i < int'(TAG_DEPTH); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Stage M: 32 element-wise products.
  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        prod_q[k] <= PW'(a_row_in[EW*k +: EW]) * PW'(b_col_in[EW*k +: EW]);
      end
    end
  end

  // Partial sums of eight products each.
  always_comb begin
    for (int p = 0; p < int'(NPART); p++) begin
      psum_c[p] = '0;
      for (int m = 0; m < int'(PER_PART); m++) begin
        psum_c[p] = psum_c[p] + PSW'(prod_q[p*PER_PART + m]);
      end
    end
  end

  // Stage T1: partial sum registers.
  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < int'(NPART); p++) begin
        psum_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NPART); p++) begin
        psum_q[p] <= psum_c[p];
      end
    end
  end

  // Final reduction of the four partial sums.
  always_comb begin
    sum_c = '0;
    for (int p = 0; p < int'(NPART); p++) begin
      sum_c = sum_c + RW'(psum_q[p]);
    end
  end

  // Stage T2: output register; payload holds while no result is valid.
  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
    end else begin
      res_valid_q <= tag_q[TAG_DEPTH-1].vld;
      if (tag_q[TAG_DEPTH-1].vld) begin
        res_data_q <= sum_c;
        res_row_q  <= tag_q[TAG_DEPTH-1].row;
        res_col_q  <= tag_q[TAG_DEPTH-1].col;
      end
    end
  end

  assign requested_a_row = row_q;
  assign requested_b_col = col_q;
  assign result_valid    = res_valid_q;
  assign result_data     = res_data_q;
  assign result_row      = res_row_q;
  assign result_col      = res_col_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
